// File: rtl/ccip_mmio_router.sv
// CCI-P c0 Rx splitter: registers c0, forwards host responses, routes MMIO requests
// into per-port show-ahead FIFOs and merges port/unmapped read responses onto c2.
module ccip_mmio_router #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned PORT_SPAN_LOG2 = 12,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      c0_rspValid,
    input  logic                      c0_mmioRdValid,
    input  logic                      c0_mmioWrValid,
    input  logic [27:0]               c0_hdr,
    input  logic [511:0]              c0_data,
    output logic                      host_rspValid,
    output logic [27:0]               host_hdr,
    output logic [511:0]              host_data,
    output logic [NUM_PORTS-1:0]      mmio_valid,
    output logic [NUM_PORTS-1:0]      mmio_is_rd,
    output logic [28*NUM_PORTS-1:0]   mmio_hdr,
    output logic [64*NUM_PORTS-1:0]   mmio_data,
    input  logic [NUM_PORTS-1:0]      mmio_ready,
    input  logic [NUM_PORTS-1:0]      port_c2_valid,
    input  logic [9*NUM_PORTS-1:0]    port_c2_tid,
    input  logic [64*NUM_PORTS-1:0]   port_c2_data,
    output logic [NUM_PORTS-1:0]      port_c2_ready,
    output logic                      c2_mmioRdValid,
    output logic [8:0]                c2_tid,
    output logic [63:0]               c2_data,
    output logic [15:0]               drop_count,
    output logic [15:0]               unmapped_count
);

    localparam int unsigned HDR_W  = 28;
    localparam int unsigned TID_W  = 9;
    localparam int unsigned DW     = 64;
    localparam int unsigned CDW    = 512;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef struct packed {
        logic             is_rd;
        logic [HDR_W-1:0] hdr;
        logic [DW-1:0]    data;
    } mmio_req_t;

    // Input stage S1
    logic             s1_rsp;
    logic             s1_rd;
    logic             s1_wr;
    logic [HDR_W-1:0] s1_hdr;
    logic [CDW-1:0]   s1_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_rsp  <= 1'b0;
            s1_rd   <= 1'b0;
            s1_wr   <= 1'b0;
            s1_hdr  <= '0;
            s1_data <= '0;
        end else begin
            s1_rsp  <= c0_rspValid;
            s1_rd   <= c0_mmioRdValid;
            s1_wr   <= c0_mmioWrValid;
            s1_hdr  <= c0_hdr;
            s1_data <= c0_data;
        end
    end

    assign host_rspValid = s1_rsp;
    assign host_hdr      = s1_hdr;
    assign host_data     = s1_data;

    // Address decode
    logic [31:0]   s1_port_full;
    logic [PW-1:0] s1_port;
    logic          s1_req;
    logic          s1_mapped;
    mmio_req_t     s1_entry;

    assign s1_port_full = 32'(s1_hdr[27:12]) >> PORT_SPAN_LOG2;
    assign s1_port      = s1_port_full[PW-1:0];
    assign s1_req       = s1_rd | s1_wr;
    assign s1_mapped    = s1_port_full < NUM_PORTS;
    assign s1_entry     = '{is_rd: s1_rd, hdr: s1_hdr, data: s1_data[DW-1:0]};

    logic [NUM_PORTS-1:0] port_drop;

    for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : g_port
        mmio_req_t   mem [FIFO_DEPTH];
        mmio_req_t   head;
        logic [AW:0] wr_ptr;
        logic [AW:0] rd_ptr;
        logic        empty;
        logic        full;
        logic        hit;
        logic        push;
        logic        pop;

        assign empty = (wr_ptr == rd_ptr);
        assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign hit   = s1_req && s1_mapped && (s1_port == PW'(p));
        assign pop   = !empty && mmio_ready[p];
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        assign push  = hit && (!full || pop);
        assign port_drop[p] = hit && full && !pop;

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
                if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr[AW-1:0]] <= s1_entry;
        end

        assign head = mem[rd_ptr[AW-1:0]];
        assign mmio_valid[p]               = !empty;
        assign mmio_is_rd[p]               = !empty && head.is_rd;
        assign mmio_hdr[p*HDR_W +: HDR_W]  = empty ? '0 : head.hdr;
        assign mmio_data[p*DW +: DW]       = empty ? '0 : head.data;
    end

    // Unmapped-read tid FIFO feeding the default responder
    logic [TID_W-1:0] unm_mem [FIFO_DEPTH];
    logic [AW:0]      unm_wr;
    logic [AW:0]      unm_rd;
    logic             unm_empty;
    logic             unm_full;
    logic             unm_hit;
    logic             unm_push;
    logic             unm_pop;
    logic             unm_drop;
    logic [TID_W-1:0] unm_head;

    assign unm_empty = (unm_wr == unm_rd);
    assign unm_full  = (unm_wr[AW] != unm_rd[AW]) && (unm_wr[AW-1:0] == unm_rd[AW-1:0]);
    assign unm_hit   = s1_req && !s1_mapped;
    assign unm_push  = unm_hit && s1_rd && !unm_full;
    assign unm_drop  = unm_hit && s1_rd && unm_full;
    assign unm_pop   = !unm_empty;
    assign unm_head  = unm_mem[unm_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            unm_wr <= '0;
            unm_rd <= '0;
        end else begin
            if (unm_push) unm_wr <= unm_wr + (AW+1)'(1);
            if (unm_pop)  unm_rd <= unm_rd + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (unm_push) unm_mem[unm_wr[AW-1:0]] <= s1_hdr[TID_W-1:0];
    end

    // Saturating event counters
    logic drop_evt;
    assign drop_evt = (|port_drop) | unm_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count     <= '0;
            unmapped_count <= '0;
        end else begin
            if (drop_evt && drop_count != '1)    drop_count     <= drop_count + CNT_W'(1);
            if (unm_hit && unmapped_count != '1) unmapped_count <= unmapped_count + CNT_W'(1);
        end
    end

    // Grants are held off during reset and the cycle after it.
    logic rst_d;
    logic grant_blk;

    always_ff @(posedge clk) begin
        rst_d <= reset;
    end
    assign grant_blk = reset | rst_d;

    // Round-robin port arbiter; the unmapped responder has absolute priority.
    logic [PW-1:0]        rr_ptr;
    logic                 grant_any;
    logic [PW-1:0]        grant_idx;
    logic [NUM_PORTS-1:0] grant_vec;
    logic [TID_W-1:0]     sel_tid;
    logic [DW-1:0]        sel_data;

    always_comb begin : p_arb
        int          j;
        logic [PW-1:0] jj;
        j         = 0;
        jj        = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        sel_tid   = '0;
        sel_data  = '0;
        if (unm_empty && !grant_blk) begin
            for (int k = 0; k < int'(NUM_PORTS); k++) begin
                j = int'(rr_ptr) + k;
                if (j >= int'(NUM_PORTS)) j = j - int'(NUM_PORTS);
                jj = PW'(j);
                if (!grant_any && port_c2_valid[jj]) begin
                    grant_any = 1'b1;
                    grant_idx = jj;
                    grant_vec = NUM_PORTS'(1) << j;
                    sel_tid   = TID_W'(port_c2_tid >> (j * int'(TID_W)));
                    sel_data  = DW'(port_c2_data >> (j * int'(DW)));
                end
            end
        end
    end

    assign port_c2_ready = grant_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    // Registered c2 output
    always_ff @(posedge clk) begin
        if (reset) begin
            c2_mmioRdValid <= 1'b0;
            c2_tid         <= '0;
            c2_data        <= '0;
        end else if (!unm_empty) begin
            c2_mmioRdValid <= 1'b1;
            c2_tid         <= unm_head;
            c2_data        <= '1;
        end else if (grant_any) begin
            c2_mmioRdValid <= 1'b1;
            c2_tid         <= sel_tid;
            c2_data        <= sel_data;
        end else begin
            c2_mmioRdValid <= 1'b0;
        end
    end

endmodule
